// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin arbiter: state encoding,
// requester count and the request-rotation helper.
package arb_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Rotate so that requester 'ptr' lands on bit 3, ptr-1 on bit 2, and so on.
  function automatic logic [NREQ-1:0] rotate(input logic [NREQ-1:0] v,
                                              input logic [IDX_W-1:0] ptr);
    logic [NREQ-1:0] r;
    r = '0;
    for (int k = 0; k < NREQ; k++) begin
      r[NREQ-1-k] = v[IDX_W'(ptr - IDX_W'(k))];
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_id;
  logic             grant_valid;
  logic             timeout;

  modport master (
    input  req,
    output grant,
    output grant_id,
    output grant_valid,
    output timeout
  );

  modport slave (
    output req,
    input  grant,
    input  grant_id,
    input  grant_valid,
    input  timeout
  );
endinterface

// File: rtl/rr_arbiter4_prio_enc4.sv
// Combinational 4:2 priority encoder, bit 3 highest, with an any-valid flag.
module prio_enc4 (
  input  logic [3:0] in,
  output logic [1:0] enc,
  output logic       valid
);

  always_comb begin
    enc   = 2'd0;
    valid = 1'b1;
    if (in[3])      enc = 2'd3;
    else if (in[2]) enc = 2'd2;
    else if (in[1]) enc = 2'd1;
    else if (in[0]) enc = 2'd0;
    else            valid = 1'b0;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter: grants are held until the owner drops
// its request or the hold limit expires, then priority rotates past the owner.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter4_if.master  bus
);

  localparam logic             TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
  logic [NREQ-1:0]  grant, grant_n;
  logic [IDX_W-1:0] grant_id, grant_id_n;
  logic             timeout, timeout_n;

  logic [NREQ-1:0]  req_rot;
  logic [IDX_W-1:0] enc;
  logic             any_req;
  logic [IDX_W-1:0] winner;

  assign req_rot = rotate(bus.req, ptr);

  prio_enc4 u_enc (
    .in    (req_rot),
    .enc   (enc),
    .valid (any_req)
  );

  // Map the encoded position in the rotated vector back to a requester index.
  assign winner = ptr - (IDX_W'(NREQ - 1) - enc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= IDX_W'(NREQ - 1);
      hold_cnt <= '0;
      grant    <= '0;
      grant_id <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_cnt_n;
      grant    <= grant_n;
      grant_id <= grant_id_n;
      timeout  <= timeout_n;
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    hold_cnt_n = hold_cnt;
    grant_n    = grant;
    grant_id_n = grant_id;
    timeout_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_n    = GRANT;
          grant_n    = NREQ'(1) << winner;
          grant_id_n = winner;
          hold_cnt_n = '0;
        end
      end
      GRANT: begin
        // Release wins over a coincident timeout, so no pulse in that case.
        if (!bus.req[grant_id]) begin
          state_n    = IDLE;
          grant_n    = '0;
          grant_id_n = '0;
          hold_cnt_n = '0;
          ptr_n      = grant_id - IDX_W'(1);
        end else if (TIMEOUT_EN && (hold_cnt == HOLD_LAST)) begin
          state_n    = IDLE;
          grant_n    = '0;
          grant_id_n = '0;
          hold_cnt_n = '0;
          timeout_n  = 1'b1;
          ptr_n      = grant_id - IDX_W'(1);
        end else if (TIMEOUT_EN) begin
          hold_cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  assign bus.grant       = grant;
  assign bus.grant_id    = grant_id;
  assign bus.grant_valid = |grant;
  assign bus.timeout     = timeout;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed, table-driven bench for rr_arbiter4 with MAX_HOLD=4, plus a
// hand-written persistent-requester sequence.
module tb_rr_arbiter4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] id;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input logic r, input logic [3:0] rq);
    rst     = r;
    bus.req = rq;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg,
                             input logic [1:0] eid, input logic et);
    logic ev;
    ev = |eg;
    checks++;
    if (bus.grant !== eg) begin
      errors++;
      $display("[TB] FAIL %s grant got %b want %b", name, bus.grant, eg);
    end
    checks++;
    if (bus.grant_valid !== ev) begin
      errors++;
      $display("[TB] FAIL %s grant_valid got %b want %b", name, bus.grant_valid, ev);
    end
    checks++;
    if (bus.timeout !== et) begin
      errors++;
      $display("[TB] FAIL %s timeout got %b want %b", name, bus.timeout, et);
    end
    if (ev) begin
      checks++;
      if (bus.grant_id !== eid) begin
        errors++;
        $display("[TB] FAIL %s grant_id got %0d want %0d", name, bus.grant_id, eid);
      end
    end
  endtask

  task automatic addVec(input string n, input logic r, input logic [3:0] rq,
                        input logic [3:0] g, input logic [1:0] id, input logic t);
    vec_t v;
    v.name = n; v.rst = r; v.req = rq; v.grant = g; v.id = id; v.tmo = t;
    vecs.push_back(v);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.req = 4'b0000;

    // reset with all requesting
    addVec("rst0",    1, 4'b1111, 4'b0000, 2'd0, 0);
    addVec("rst1",    1, 4'b1111, 4'b0000, 2'd0, 0);
    addVec("first",   0, 4'b1111, 4'b1000, 2'd3, 0);
    // rotation 3,2,1,0,3 with one bubble each
    addVec("rot3a",   0, 4'b1111, 4'b1000, 2'd3, 0);
    addVec("rot3b",   0, 4'b1111, 4'b1000, 2'd3, 0);
    addVec("rot3rel", 0, 4'b0111, 4'b0000, 2'd0, 0);
    addVec("rot2",    0, 4'b1111, 4'b0100, 2'd2, 0);
    addVec("rot2a",   0, 4'b1111, 4'b0100, 2'd2, 0);
    addVec("rot2b",   0, 4'b1111, 4'b0100, 2'd2, 0);
    addVec("rot2rel", 0, 4'b1011, 4'b0000, 2'd0, 0);
    addVec("rot1",    0, 4'b1111, 4'b0010, 2'd1, 0);
    addVec("rot1a",   0, 4'b1111, 4'b0010, 2'd1, 0);
    addVec("rot1b",   0, 4'b1111, 4'b0010, 2'd1, 0);
    addVec("rot1rel", 0, 4'b1101, 4'b0000, 2'd0, 0);
    addVec("rot0",    0, 4'b1111, 4'b0001, 2'd0, 0);
    addVec("rot0a",   0, 4'b1111, 4'b0001, 2'd0, 0);
    addVec("rot0b",   0, 4'b1111, 4'b0001, 2'd0, 0);
    addVec("rot0rel", 0, 4'b1110, 4'b0000, 2'd0, 0);
    addVec("rot3again", 0, 4'b1111, 4'b1000, 2'd3, 0);
    // sparse requests from reset
    addVec("sp_rst",  1, 4'b0000, 4'b0000, 2'd0, 0);
    addVec("sp2",     0, 4'b0101, 4'b0100, 2'd2, 0);
    addVec("sp2rel",  0, 4'b0001, 4'b0000, 2'd0, 0);
    addVec("sp0",     0, 4'b0101, 4'b0001, 2'd0, 0);
    addVec("sp0rel",  0, 4'b0100, 4'b0000, 2'd0, 0);
    addVec("sp2b",    0, 4'b0101, 4'b0100, 2'd2, 0);
    addVec("sp2brel", 0, 4'b0000, 4'b0000, 2'd0, 0);
    addVec("idle",    0, 4'b0000, 4'b0000, 2'd0, 0);
    // timeout after 4 cycles, then re-grant
    addVec("to_g0",   0, 4'b0010, 4'b0010, 2'd1, 0);
    addVec("to_g1",   0, 4'b0010, 4'b0010, 2'd1, 0);
    addVec("to_g2",   0, 4'b0010, 4'b0010, 2'd1, 0);
    addVec("to_g3",   0, 4'b0010, 4'b0010, 2'd1, 0);
    addVec("to_fire", 0, 4'b0010, 4'b0000, 2'd0, 1);
    addVec("to_regr", 0, 4'b0010, 4'b0010, 2'd1, 0);
    // no preemption, then release coinciding with the hold limit
    addVec("np1",     0, 4'b1010, 4'b0010, 2'd1, 0);
    addVec("np2",     0, 4'b1010, 4'b0010, 2'd1, 0);
    addVec("np3",     0, 4'b1010, 4'b0010, 2'd1, 0);
    addVec("simul",   0, 4'b1000, 4'b0000, 2'd0, 0);
    addVec("after_sim", 0, 4'b1000, 4'b1000, 2'd3, 0);
    addVec("rel3",    0, 4'b0000, 4'b0000, 2'd0, 0);
    // reset in the middle of a grant
    addVec("mg2",     0, 4'b0100, 4'b0100, 2'd2, 0);
    addVec("mg2a",    0, 4'b0100, 4'b0100, 2'd2, 0);
    addVec("mg_rst",  1, 4'b0100, 4'b0000, 2'd0, 0);
    addVec("mg_post", 0, 4'b1100, 4'b1000, 2'd3, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].req);
      checkOutput(vecs[i].name, vecs[i].grant, vecs[i].id, vecs[i].tmo);
    end

    // Persistent single requester: 4 cycles on, 1 off with a timeout pulse.
    applyStimulus(1'b1, 4'b0000);
    checkOutput("pers_rst", 4'b0000, 2'd0, 1'b0);
    for (int n = 1; n <= 15; n++) begin
      applyStimulus(1'b0, 4'b0001);
      if ((n % 5) != 0) checkOutput($sformatf("pers%0d", n), 4'b0001, 2'd0, 1'b0);
      else              checkOutput($sformatf("pers%0d", n), 4'b0000, 2'd0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
